// File: rtl/uart_periph_pkg.sv
// Shared definitions for the UART peripherals on the APB bus:
// the register address map, register bit positions and receive FSM states.
package uart_periph_pkg;

    // Register byte addresses within the 5-bit APB window
    localparam logic [4:0] FSR_ADDR = 5'h00;
    localparam logic [4:0] FRD_ADDR = 5'h08;
    localparam logic [4:0] BRR_ADDR = 5'h0C;
    localparam logic [4:0] UCR_ADDR = 5'h10;

    // FSR bit positions; the entry count occupies bits [7:4]
    localparam int FSR_EMPTY = 0;
    localparam int FSR_FULL  = 1;
    localparam int FSR_OVR   = 2;
    localparam int FSR_FE    = 3;

    // UCR bit positions
    localparam int UCR_EN    = 0;
    localparam int UCR_RXEN  = 1;
    localparam int UCR_FLUSH = 2;
    localparam int UCR_IRQEN = 3;

    // Receive FSM states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO for the UART receiver. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; flush
// empties the FIFO and overrides any push or pop in that cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Decide which requests actually take effect this cycle
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Pointer and occupancy bookkeeping; flush simply rewinds everything
    always_ff @(posedge PCLK) begin
        if (PRESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge PCLK) begin
        if (do_push && !flush && !PRESET) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_periph.sv
// APB3 UART receive peripheral: synchronizes the serial input, deframes
// 8N1 characters, queues them in a small FIFO and exposes status, data,
// baud and control registers with zero-wait-state APB access.
module uart_rx_periph
    import uart_periph_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BRR_RESET  = 868
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        rx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Register state
    logic [15:0]   brr;
    logic          ucr_en;
    logic          ucr_rxen;
    logic          ucr_irqen;
    logic          ovr;
    logic          fe;

    // Synchronizer and receive FSM state
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_e     state;
    logic [15:0]   cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    // Decode and datapath signals
    logic          access;
    logic          wr_en;
    logic          rd_en;
    logic          sel_fsr;
    logic          sel_frd;
    logic          sel_brr;
    logic          sel_ucr;
    logic          active;
    logic [15:0]   brr_eff;
    logic [15:0]   half_bit;
    logic          bit_done;
    logic          half_done;
    logic          rx_fall;
    logic          push;
    logic          fe_set;
    logic          ovr_set;
    logic          pop;
    logic          flush;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]    fsr_count;
    logic          unused_bits;

    assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

    // APB decode; the slave never inserts wait states
    always_comb begin
        access  = PSEL & PENABLE;
        PREADY  = access;
        wr_en   = access & PWRITE;
        rd_en   = access & ~PWRITE;
        sel_fsr = (PADDR[4:2] == FSR_ADDR[4:2]);
        sel_frd = (PADDR[4:2] == FRD_ADDR[4:2]);
        sel_brr = (PADDR[4:2] == BRR_ADDR[4:2]);
        sel_ucr = (PADDR[4:2] == UCR_ADDR[4:2]);
        pop     = rd_en & sel_frd & ~fifo_empty;
        flush   = wr_en & sel_ucr & PWDATA[UCR_FLUSH];
    end

    // Bit timing and FSM sample strobes; very small divisors are clamped to 4
    always_comb begin
        active    = ucr_en & ucr_rxen;
        brr_eff   = (brr < 16'd4) ? 16'd4 : brr;
        half_bit  = brr_eff >> 1;
        bit_done  = (cnt == brr_eff - 16'd1);
        half_done = (cnt == half_bit - 16'd1);
        rx_fall   = rx_prev & ~rx_sync;
        push      = active && (state == STOP) && bit_done && rx_sync;
        fe_set    = active && (state == STOP) && bit_done && !rx_sync;
        ovr_set   = push & fifo_full & ~pop & ~flush;
    end

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive FSM: deframes one 8N1 character, abandoning it when disabled
    always_ff @(posedge PCLK) begin
        if (PRESET || !active) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state   <= START;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (half_done) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BREAK: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Control/baud registers and sticky error flags; a same-cycle set beats a W1C clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            brr       <= 16'(BRR_RESET);
            ucr_en    <= 1'b0;
            ucr_rxen  <= 1'b0;
            ucr_irqen <= 1'b0;
            ovr       <= 1'b0;
            fe        <= 1'b0;
        end else begin
            if (wr_en && sel_brr) begin
                brr <= PWDATA[15:0];
            end
            if (wr_en && sel_ucr) begin
                ucr_en    <= PWDATA[UCR_EN];
                ucr_rxen  <= PWDATA[UCR_RXEN];
                ucr_irqen <= PWDATA[UCR_IRQEN];
            end
            ovr <= ovr_set | (ovr & ~(wr_en & sel_fsr & PWDATA[FSR_OVR]));
            fe  <= fe_set  | (fe  & ~(wr_en & sel_fsr & PWDATA[FSR_FE]));
        end
    end

    // Level interrupt registered from the FIFO occupancy
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_irq <= 1'b0;
        end else begin
            rx_irq <= ~fifo_empty & ucr_irqen;
        end
    end

    // A 16-deep FIFO reports count 0 in the 4-bit field when full; the full bit disambiguates
    assign fsr_count = 4'(fifo_count);

    // Read mux, driven only during the access phase
    always_comb begin
        PRDATA = '0;
        if (access) begin
            if (sel_fsr) begin
                PRDATA[7:4]       = fsr_count;
                PRDATA[FSR_FE]    = fe;
                PRDATA[FSR_OVR]   = ovr;
                PRDATA[FSR_FULL]  = fifo_full;
                PRDATA[FSR_EMPTY] = fifo_empty;
            end else if (sel_frd) begin
                PRDATA[7:0] = fifo_empty ? 8'h00 : fifo_dout;
            end else if (sel_brr) begin
                PRDATA[15:0] = brr;
            end else if (sel_ucr) begin
                PRDATA[UCR_EN]    = ucr_en;
                PRDATA[UCR_RXEN]  = ucr_rxen;
                PRDATA[UCR_IRQEN] = ucr_irqen;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (shreg),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph: drives APB accesses and serial frames
// and compares register contents against hand-computed values.
module tb_uart_rx_periph;
    import uart_periph_pkg::*;

    logic        PCLK;
    logic        PRESET;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx;
    logic        rx_irq;

    int          checks;
    int          errors;
    int          bit_cycles;
    logic [31:0] rd;

    uart_rx_periph #(
        .FIFO_DEPTH (4),
        .BRR_RESET  (868)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .rx      (rx),
        .rx_irq  (rx_irq)
    );

    // 10 ns clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] addr, output logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (bit_cycles) @(posedge PCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset;
        PRESET = 1'b1; rx = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        checks++;
        if (PREADY !== 1'b0) begin errors++; $display("[TB] FAIL reset_pready got %b expected 0", PREADY); end
        checks++;
        if (PRDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_prdata got %h expected 0", PRDATA); end
        checks++;
        if (rx_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b expected 0", rx_irq); end
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = BRR_ADDR;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        checks++;
        if (PREADY !== 1'b1) begin errors++; $display("[TB] FAIL access_pready got %b expected 1", PREADY); end
        checks++;
        if (PRDATA !== 32'd868) begin errors++; $display("[TB] FAIL reset_brr got %h expected %h", PRDATA, 32'd868); end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL reset_fsr got %h expected 01", rd); end
        apb_read(UCR_ADDR, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_ucr got %h expected 0", rd); end
    endtask

    task automatic test_single_byte;
        apb_write(BRR_ADDR, 32'd16);
        apb_write(UCR_ADDR, 32'h3);
        send_frame(8'hA5, 1'b1);
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("[TB] FAIL single_fsr got %h expected 10", rd); end
        apb_read(FRD_ADDR, rd);
        checks++;
        if (rd !== 32'hA5) begin errors++; $display("[TB] FAIL single_frd got %h expected a5", rd); end
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL single_fsr_after got %h expected 01", rd); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_bytes [4];
        exp_bytes[0] = 8'h5A; exp_bytes[1] = 8'h6A; exp_bytes[2] = 8'h7A; exp_bytes[3] = 8'h8A;
        send_frame(8'h5A, 1'b1);
        send_frame(8'h6A, 1'b1);
        send_frame(8'h7A, 1'b1);
        send_frame(8'h8A, 1'b1);
        send_frame(8'h9A, 1'b1);
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h46) begin errors++; $display("[TB] FAIL overrun_fsr got %h expected 46", rd); end
        for (int i = 0; i < 4; i++) begin
            apb_read(FRD_ADDR, rd);
            checks++;
            if (rd !== {24'h0, exp_bytes[i]}) begin
                errors++; $display("[TB] FAIL b2b_frd%0d got %h expected %h", i, rd, exp_bytes[i]);
            end
        end
        apb_read(FRD_ADDR, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL empty_frd got %h expected 0", rd); end
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("[TB] FAIL ovr_sticky got %h expected 05", rd); end
        apb_write(FSR_ADDR, 32'h04);
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL ovr_clear got %h expected 01", rd); end
    endtask

    task automatic test_frame_error;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (20 * bit_cycles) @(posedge PCLK);
        #1 rx = 1'b1;
        repeat (8) @(posedge PCLK);
        #1;
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h09) begin errors++; $display("[TB] FAIL fe_fsr got %h expected 09", rd); end
        apb_write(FSR_ADDR, 32'h08);
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL fe_clear got %h expected 01", rd); end
    endtask

    task automatic test_false_start;
        rx = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 rx = 1'b1;
        repeat (40) @(posedge PCLK);
        #1;
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL glitch_state got %0d expected %0d", dut.state, IDLE); end
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL glitch_fsr got %h expected 01", rd); end
    endtask

    task automatic test_disable_midframe;
        logic [7:0] d;
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        apb_write(UCR_ADDR, 32'h0);
        for (int i = 4; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        repeat (4) @(posedge PCLK);
        #1;
        apb_write(UCR_ADDR, 32'h3);
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL disable_nopush got %h expected 01", rd); end
        send_frame(8'h3C, 1'b1);
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h10) begin errors++; $display("[TB] FAIL reenable_fsr got %h expected 10", rd); end
        apb_read(FRD_ADDR, rd);
        checks++;
        if (rd !== 32'h3C) begin errors++; $display("[TB] FAIL reenable_frd got %h expected 3c", rd); end
    endtask

    task automatic test_irq_flush;
        send_frame(8'h11, 1'b1);
        apb_write(UCR_ADDR, 32'hB);
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (rx_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set got %b expected 1", rx_irq); end
        apb_write(UCR_ADDR, 32'hF);
        @(posedge PCLK); #1;
        checks++;
        if (rx_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_flush got %b expected 0", rx_irq); end
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL flush_fsr got %h expected 01", rd); end
        apb_read(UCR_ADDR, rd);
        checks++;
        if (rd !== 32'h0B) begin errors++; $display("[TB] FAIL ucr_readback got %h expected 0b", rd); end
    endtask

    task automatic test_reset_midframe;
        send_frame(8'h22, 1'b1);
        checks++;
        if (rx_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_before_reset got %b expected 1", rx_irq); end
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        rx = 1'b1;
        checks++;
        if (rx_irq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_irq got %b expected 0", rx_irq); end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL midreset_state got %0d expected %0d", dut.state, IDLE); end
        apb_read(FSR_ADDR, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("[TB] FAIL midreset_fsr got %h expected 01", rd); end
        apb_read(BRR_ADDR, rd);
        checks++;
        if (rd !== 32'd868) begin errors++; $display("[TB] FAIL midreset_brr got %h expected %h", rd, 32'd868); end
        apb_read(UCR_ADDR, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midreset_ucr got %h expected 0", rd); end
    endtask

    // Scenario sequence
    initial begin
        checks = 0;
        errors = 0;
        bit_cycles = 16;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_false_start();
        test_disable_midframe();
        test_irq_flush();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_periph.md
# uart_rx_periph

APB3 slave peripheral that receives 8N1 UART frames on `rx`, buffers received bytes in a small FIFO, and exposes status, data, baud and control registers on the same 5-bit APB address window used by the UART TX peripheral. It is the receive-side counterpart on the peripheral bus and plugs into the APB decoder as one more slave select.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, 2..16.
- `BRR_RESET`, 868: reset value of the baud register (PCLK cycles per bit).
- `PCLK` in 1: single clock; all state updates on rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `PADDR` in 5: byte address; bits [1:0] ignored.
- `PWDATA` in 32: write data.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PENABLE` in 1: APB access phase.
- `PSEL` in 1: slave select.
- `PRDATA` out 32: read data, valid while `PREADY` = 1.
- `PREADY` out 1: transfer complete.
- `rx` in 1: asynchronous serial input, idle high.
- `rx_irq` out 1: level interrupt, 1 when FIFO non-empty and UCR[3] = 1.

## Operation
- Register map:
  - 0x00 FSR: [0] empty, [1] full, [2] overrun (W1C), [3] frame error (W1C), [7:4] entry count.
  - 0x08 FRD: read-only; [7:0] head byte; a read pops.
  - 0x0C BRR: [15:0] cycles per bit; values below 4 behave as 4.
  - 0x10 UCR: [0] enable, [1] rx_enable, [2] flush (write 1, self-clearing, reads 0), [3] irq_enable.
  - Other addresses: read 0, writes ignored.
- `rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized value.
- FSM, active only while UCR[0] and UCR[1] are both 1:
  - IDLE: on synchronized falling edge → START; clear bit counter.
  - START: after floor(BRR/2) cycles, sample; low → DATA, high → IDLE (false start).
  - DATA: sample every BRR cycles, 8 bits LSB first → STOP.
  - STOP: sample after BRR cycles; high → push byte, IDLE; low → set FE, discard byte, BREAK.
  - BREAK: wait for synchronized `rx` = 1 → IDLE.
- Push when full: byte discarded, OVR set, FIFO unchanged.
- FRD read when empty: PRDATA = 0, no state change.
- Push and pop in the same cycle: both succeed, including when full (no OVR); count unchanged.
- Flush and push in the same cycle: flush wins, byte lost, no flag set.
- Clearing UCR[0] or UCR[1] mid-frame: FSM → IDLE next cycle; partial byte discarded; FIFO and flags retained.
- W1C: writing 1 to FSR[2]/[3] clears that flag; a same-cycle set wins over the clear.

## Timing
- Reset values: PRDATA 0, PREADY 0, rx_irq 0, FSM IDLE, FIFO empty, OVR/FE 0, BRR = `BRR_RESET`, UCR = 0.
- APB zero-wait: PREADY = PSEL & PENABLE, combinational. PRDATA is combinational from the address in the access phase and 0 otherwise.
- Register writes and FIFO pop take effect on the PCLK edge that ends the access phase (PSEL & PENABLE & PREADY).
- `rx` to FSM latency: 2 cycles.
- Byte visible in FRD/FSR on the cycle after the stop-bit sample edge.
- Frame length from start edge to push ≈ 2 + floor(BRR/2) + 9·BRR cycles.
- `rx_irq` is registered from FIFO state and lags FSR by at most 1 cycle.

## Structure
- Package `uart_periph_pkg` holds:
  - address constants FSR/FRD/BRR/UCR;
  - FSR and UCR bit-index constants;
  - the `rx_state_e` enum (IDLE, START, DATA, STOP, BREAK).
- Sub-module `uart_rx_fifo`: synchronous FIFO with push, pop, flush, full, empty and count. Same-cycle push and pop when full are allowed.
- The top module contains the APB decode, registers, synchronizer and receive FSM.

## Test plan
- BRR = 16, UCR = 0x3, drive frame 0xA5 → FSR = 0x10 (count 1, not empty); FRD read = 0xA5; FSR then = 0x01.
- Drive 0x5A, 0x6A, 0x7A, 0x8A, 0x9A back-to-back without reading → FSR = 0x46 (count 4, full, OVR); four FRD reads return 0x5A, 0x6A, 0x7A, 0x8A; then FRD reads 0.
- Drive a frame with stop bit low, then hold `rx` low for 20 bit times, then idle → FE set, FIFO empty, no byte; write FSR 0x08 → FE = 0.
- Drive a 3-cycle low glitch with BRR = 16 → false start, no push, FSM back in IDLE.
- Write UCR = 0x0 after the 4th data bit, then re-enable → no push; the next complete frame 0x3C is received correctly.
- Set UCR = 0xB with the FIFO non-empty → rx_irq = 1; write UCR[2] flush → count 0 and rx_irq = 0 within 1 cycle. Apply PRESET mid-frame → all registers at reset values.
